// File: rtl/slv_arb_pkg.sv
// Shared types and helpers for the round-robin slave-port arbiter.
// State encoding, pointer sizing and a one-hot to index encoder.
package slv_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int NM_MAX = 8;
  localparam int NM_DEF = 4;
  localparam int PTR_W  = $clog2(NM_DEF);

  // OR-reduction encoder; a zero input yields index 0.
  function automatic logic [2:0] onehot2idx(input logic [NM_MAX-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NM_MAX; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/slv_bus_arbiter_rr_pick.sv
// Combinational circular priority picker: first requester at or after the pointer.
// Zero latency; oValid is low when nobody requests.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  iReq,
  input  logic [PW-1:0] iPtr,
  output logic [PW-1:0] oIdx,
  output logic          oValid
);

  logic [PW:0] cand;

  // Walk from the farthest offset back to the pointer so the nearest requester wins.
  always_comb begin
    oIdx   = '0;
    oValid = |iReq;
    cand   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, iPtr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (iReq[cand[PW-1:0]]) oIdx = cand[PW-1:0];
    end
  end

endmodule

// File: rtl/slv_bus_arbiter.sv
// Round-robin arbiter sharing one slave port among NM masters; the grant is held until ack.
// Optional watchdog under SLV_ARB_TIMEOUT_EN aborts a transfer after TO_CYC unacked BUSY cycles.
module slv_bus_arbiter
  import slv_arb_pkg::*;
#(
  parameter int NM     = 4,
  parameter int CMD_W  = 1,
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int SW     = 4,
  parameter int TO_CYC = 64
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [NM-1:0]       iMstReq,
  input  logic [NM*CMD_W-1:0] iMstCmd,
  input  logic [NM*AW-1:0]    iMstAddr,
  input  logic [NM*SW-1:0]    iMstSel,
  input  logic [NM*DW-1:0]    iMstWData,
  output logic [NM-1:0]       oMstAck,
  output logic [DW-1:0]       oMstRData,
  output logic [NM-1:0]       oMstErr,
  output logic [NM-1:0]       oGnt,
  output logic                oSlvReq,
  output logic [CMD_W-1:0]    oSlvCmd,
  output logic [AW-1:0]       oSlvAddr,
  output logic [SW-1:0]       oSlvSel,
  output logic [DW-1:0]       oSlvWData,
  input  logic                iSlvAck,
  input  logic [DW-1:0]       iSlvRData
);

  localparam int PW = $clog2(NM);

  state_t        state;
  logic [NM-1:0] gnt_q;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] g;
  logic [PW-1:0] nxt_ptr;
  logic [PW-1:0] pick_idx;
  logic          pick_vld;
  logic          busy;
  logic          req_g;
  logic          ack_g;
  logic          to_hit;
  logic          end_xfer;

  rr_pick #(.N(NM), .PW(PW)) u_pick (
    .iReq   (iMstReq),
    .iPtr   (rr_ptr),
    .oIdx   (pick_idx),
    .oValid (pick_vld)
  );

  assign g       = PW'(onehot2idx(NM_MAX'(gnt_q)));
  assign nxt_ptr = (g == PW'(NM - 1)) ? '0 : g + PW'(1);
  assign busy    = (state == ST_BUSY);
  assign req_g   = iMstReq[g];

`ifdef SLV_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC) + 1;
  logic [TW-1:0] timer;

  assign to_hit = busy && (timer == TW'(TO_CYC - 1));

  // Counts unacked BUSY cycles; held at zero outside BUSY so each grant starts fresh.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      timer <= '0;
    end else if (!busy || end_xfer) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // Slave side is driven only while a grant is held, so state reset kills it asynchronously.
  assign oSlvReq   = busy & req_g & ~to_hit;
  assign oSlvCmd   = busy ? iMstCmd[g*CMD_W +: CMD_W] : '0;
  assign oSlvAddr  = busy ? iMstAddr[g*AW +: AW]      : '0;
  assign oSlvSel   = busy ? iMstSel[g*SW +: SW]       : '0;
  assign oSlvWData = busy ? iMstWData[g*DW +: DW]     : '0;

  assign ack_g     = iSlvAck & oSlvReq;
  assign oMstAck   = ack_g  ? (NM'(1) << g) : '0;
  assign oMstErr   = to_hit ? (NM'(1) << g) : '0;
  assign oMstRData = ack_g  ? iSlvRData     : '0;
  assign oGnt      = gnt_q;

  // A dropped request, an ack or a watchdog expiry all release the grant the same way.
  assign end_xfer = ~req_g | ack_g | to_hit;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= ST_IDLE;
      gnt_q  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_q <= NM'(1) << pick_idx;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (end_xfer) begin
            gnt_q  <= '0;
            rr_ptr <= nxt_ptr;
            state  <= ST_IDLE;
          end
        end
        default: begin
          gnt_q <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slv_bus_arbiter.sv
// Bench for slv_bus_arbiter: vector table, hand sequences for all-request/abort/reset,
// and randomized traffic checked against a round-robin reference model.
module tb_slv_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   mreq = '0;
  logic [3:0]   mcmd = '0;
  logic [47:0]  maddr = '0;
  logic [15:0]  msel = '0;
  logic [127:0] mwdata = '0;
  logic [3:0]   ack;
  logic [31:0]  rdata;
  logic [3:0]   err;
  logic [3:0]   gnt;
  logic         slv_req;
  logic [0:0]   slv_cmd;
  logic [11:0]  slv_addr;
  logic [3:0]   slv_sel;
  logic [31:0]  slv_wdata;
  logic         slv_ack;
  logic [31:0]  slv_rdata;

  int checks = 0;
  int failures = 0;
  int sdelay = 0;
  int scnt = 0;

  logic [31:0] smem [0:1023] = '{default: 32'h0};
  logic [31:0] mm   [0:1023] = '{default: 32'h0};

  slv_bus_arbiter dut (
    .iClk      (clk),
    .iRst      (rst),
    .iMstReq   (mreq),
    .iMstCmd   (mcmd),
    .iMstAddr  (maddr),
    .iMstSel   (msel),
    .iMstWData (mwdata),
    .oMstAck   (ack),
    .oMstRData (rdata),
    .oMstErr   (err),
    .oGnt      (gnt),
    .oSlvReq   (slv_req),
    .oSlvCmd   (slv_cmd),
    .oSlvAddr  (slv_addr),
    .oSlvSel   (slv_sel),
    .oSlvWData (slv_wdata),
    .iSlvAck   (slv_ack),
    .iSlvRData (slv_rdata)
  );

  always #5 clk = ~clk;

  // Slave memory: acks after sdelay cycles of a held request (0 = same cycle).
  assign slv_ack   = slv_req && (scnt == sdelay);
  assign slv_rdata = smem[slv_addr[11:2]];

  always @(posedge clk) begin
    if (!slv_req || slv_ack) scnt <= 0;
    else scnt <= scnt + 1;
    if (slv_ack && slv_cmd == 1'b0) begin
      for (int b = 0; b < 4; b++)
        if (slv_sel[b]) smem[slv_addr[11:2]][8*b +: 8] <= slv_wdata[8*b +: 8];
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // The slave must never see a request without a grant; the watchdog is absent here.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((slv_req && gnt == 4'b0) || err != 4'b0) begin
        failures++;
        $display("FAIL invariant actual=req%0b gnt%0h err%0h required=no-req-without-gnt err0",
                 slv_req, gnt, err);
      end
    end
  end

  task automatic set_m(input int m, input logic cmd, input logic [11:0] addr,
                       input logic [3:0] sel, input logic [31:0] wd);
    mcmd[m] = cmd;
    maddr[m*12 +: 12] = addr;
    msel[m*4 +: 4] = sel;
    mwdata[m*32 +: 32] = wd;
  endtask

  // Called at an idle negedge with master m requesting; ends at the turnaround negedge.
  task automatic expect_xfer(input int m, input int dly, input logic rd,
                             input logic [31:0] exp_rd, input logic [31:0] mask);
    int n;
    @(negedge clk);
    check("grant", 64'(gnt), 64'(1) << m);
    n = 0;
    while (!ack[m] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ack_latency", 64'(n), 64'(dly));
    check("ack_onehot", 64'(ack), 64'(1) << m);
    if (rd) check("rdata", 64'(rdata & mask), 64'(exp_rd & mask));
    @(negedge clk);
    check("turnaround_gnt", 64'(gnt), 64'(0));
    mreq[m] = 1'b0;
  endtask

  typedef struct {
    int          m;
    logic        cmd;
    logic [11:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] exp_rd;
    logic [31:0] mask;
  } vec_t;

  vec_t vt [7];

  initial begin
    int w, mptr, idx;
    logic found;

    vt[0] = '{2, 1'b0, 12'h010, 4'hF,    32'hA5A5A5A5, 0, 32'h0,        32'h0};
    vt[1] = '{2, 1'b1, 12'h010, 4'hF,    32'h0,        0, 32'hA5A5A5A5, 32'hFFFFFFFF};
    vt[2] = '{1, 1'b0, 12'h020, 4'hF,    32'h12345678, 0, 32'h0,        32'h0};
    vt[3] = '{1, 1'b1, 12'h020, 4'b0011, 32'h0,        0, 32'h00005678, 32'h0000FFFF};
    vt[4] = '{0, 1'b0, 12'h030, 4'b1100, 32'hDEADBEEF, 2, 32'h0,        32'h0};
    vt[5] = '{0, 1'b1, 12'h030, 4'hF,    32'h0,        1, 32'hDEAD0000, 32'hFFFFFFFF};
    vt[6] = '{3, 1'b1, 12'h010, 4'hF,    32'h0,        5, 32'hA5A5A5A5, 32'hFFFFFFFF};

    // Reset: requests present while reset is held must not be granted.
    mreq = 4'hF;
    #3;
    check("rst_outputs", {28'h0, gnt, ack, err, slv_req, slv_cmd, slv_addr, slv_sel},
          64'(0));
    @(posedge clk); #1;
    check("rst_hold_gnt", 64'(gnt), 64'(0));
    check("rst_hold_slvreq", 64'(slv_req), 64'(0));
    mreq = 4'h0;
    @(negedge clk);
    rst = 1'b0;

    // Single-master table: writes, byte-select read, slave delays 0/1/2/5.
    for (int i = 0; i < 7; i++) begin
      set_m(vt[i].m, vt[i].cmd, vt[i].addr, vt[i].sel, vt[i].wdata);
      mreq[vt[i].m] = 1'b1;
      sdelay = vt[i].dly;
      expect_xfer(vt[i].m, vt[i].dly, vt[i].cmd, vt[i].exp_rd, vt[i].mask);
    end

    // All masters requesting: 0,1,2,3,0 with an idle cycle after each transfer.
    for (int m = 0; m < 4; m++) set_m(m, 1'b1, 12'h010, 4'hF, 32'h0);
    sdelay = 0;
    mreq = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("allreq_gnt", 64'(gnt), (i % 2 == 0) ? (64'(1) << ((i / 2) % 4)) : 64'(0));
      check("allreq_ack", 64'(ack), (i % 2 == 0) ? (64'(1) << ((i / 2) % 4)) : 64'(0));
    end
    mreq = 4'h0;

    // Abort: master 2 drops its request mid-transfer; pointer must move past it.
    mreq = 4'b0100;
    sdelay = 10;
    @(negedge clk);
    check("abort_gnt", 64'(gnt), 64'(4'b0100));
    @(negedge clk);
    @(negedge clk);
    mreq[2] = 1'b0;
    #1;
    check("abort_slvreq", 64'(slv_req), 64'(0));
    check("abort_ack", 64'(ack), 64'(0));
    @(negedge clk);
    check("abort_idle", 64'(gnt), 64'(0));
    sdelay = 0;
    mreq = 4'b0011;
    @(negedge clk);
    check("abort_ptr_gnt", 64'(gnt), 64'(4'b0001));
    check("abort_ptr_ack", 64'(ack), 64'(4'b0001));
    @(negedge clk);
    mreq = 4'h0;

    // Reset in the middle of a transfer drops the slave request immediately.
    mreq = 4'b0100;
    sdelay = 10;
    @(negedge clk);
    check("midrst_gnt", 64'(gnt), 64'(4'b0100));
    check("midrst_slvreq_pre", 64'(slv_req), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("midrst_slvreq", 64'(slv_req), 64'(0));
    check("midrst_gnt0", 64'(gnt), 64'(0));
    mreq = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized traffic against a round-robin reference model (pointer reset to 0).
    mptr = 0;
    for (int t = 0; t < 40; t++) begin
      for (int m = 0; m < 4; m++) begin
        if (!mreq[m] && ($urandom_range(0, 1) == 1 || (mreq == 4'h0 && m == 3))) begin
          set_m(m, 1'($urandom_range(0, 1)), 12'h100 + 12'(4 * $urandom_range(0, 15)),
                4'($urandom_range(1, 15)), $urandom);
          mreq[m] = 1'b1;
        end
      end
      sdelay = $urandom_range(0, 3);
      w = 0;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!found && mreq[(mptr + k) % 4]) begin
          w = (mptr + k) % 4;
          found = 1'b1;
        end
      end
      idx = int'(maddr[w*12 + 2 +: 10]);
      expect_xfer(w, sdelay, mcmd[w], mm[idx], 32'hFFFFFFFF);
      if (mcmd[w] == 1'b0) begin
        for (int b = 0; b < 4; b++)
          if (msel[w*4 + b]) mm[idx][8*b +: 8] = mwdata[w*32 + 8*b +: 8];
      end
      mptr = (w + 1) % 4;
    end
    mreq = 4'h0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
